// File: rtl/iir_pkg.sv
// Shared constants and helpers for the single-pole shift-coefficient IIR filter.
package iir_pkg;

    // Default geometry of the filter.
    localparam int DEF_W       = 8;
    localparam int DEF_NCH     = 4;
    localparam int DEF_A_SHIFT = 2;
    localparam int DEF_B_SHIFT = 1;

    // Width of a channel index: never narrower than one bit, even for a single channel.
    function automatic int chan_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/iir_sat.sv
// Combinational saturator: folds a (W+1)-bit two's complement sum into W bits,
// clipping to the most positive / most negative value and flagging the clip.
module iir_sat
    import iir_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic signed [W:0]   d,
    output logic signed [W-1:0] q,
    output logic                clip
);

    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    // The sum overflowed W bits exactly when its two top bits disagree; the top bit gives the direction.
    always_comb begin
        q    = d[W-1:0];
        clip = 1'b0;
        if (d[W] != d[W-1]) begin
            clip = 1'b1;
            if (d[W]) begin
                q = MIN_VAL;
            end else begin
                q = MAX_VAL;
            end
        end else begin
            clip = 1'b0;
            q    = d[W-1:0];
        end
    end

endmodule

// File: rtl/iir1_shift_filter.sv
// Time-multiplexed first-order IIR filter:
//   y_c(n) = sat( (y_c(n-1) >>> A_SHIFT) + (x(n) >>> B_SHIFT) )
// One state word per channel, one-entry registered output with backpressure.
module iir1_shift_filter
    import iir_pkg::*;
#(
    parameter  int W       = DEF_W,
    parameter  int NCH     = DEF_NCH,
    parameter  int A_SHIFT = DEF_A_SHIFT,
    parameter  int B_SHIFT = DEF_B_SHIFT,
    localparam int CW      = chan_width(NCH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x,
    input  logic [CW-1:0]       in_ch,
    input  logic                clr,
    input  logic [CW-1:0]       clr_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] y,
    output logic [CW-1:0]       out_ch,
    output logic                sat
);

    localparam int NIDX = 1 << CW;

    // Per-channel state: the saturated result each channel last produced.
    logic signed [W-1:0] state_r [NCH];

    // Output register.
    logic                out_valid_r;
    logic signed [W-1:0] y_r;
    logic [CW-1:0]       out_ch_r;
    logic                sat_r;

    // Datapath and control.
    logic [NIDX-1:0]     ch_ok_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                take_s;
    logic                clr_take_s;
    logic signed [W-1:0] prev_s;
    logic signed [W:0]   prev_ext_s;
    logic signed [W:0]   x_ext_s;
    logic signed [W:0]   fb_term_s;
    logic signed [W:0]   in_term_s;
    logic signed [W:0]   sum_s;
    logic signed [W-1:0] sat_y_s;
    logic                sat_clip_s;

    // Table of which encodable channel indices actually exist; indices >= NCH are dropped.
    always_comb begin
        ch_ok_s = '0;
        for (int i = 0; i < NIDX; i++) begin
            if (i < NCH) begin
                ch_ok_s[i] = 1'b1;
            end else begin
                ch_ok_s[i] = 1'b0;
            end
        end
    end

    // Handshake: the output slot is free when empty or being drained this cycle.
    always_comb begin
        in_ready_s = !out_valid_r || out_ready;
        accept_s   = in_valid && in_ready_s;
        take_s     = accept_s && ch_ok_s[in_ch];
        clr_take_s = clr && ch_ok_s[clr_ch];
    end

    // Fetch the previous output of the addressed channel; a same-cycle clear of that channel reads as zero.
    always_comb begin
        prev_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ch == CW'(i)) begin
                prev_s = state_r[i];
            end else begin
                prev_s = prev_s;
            end
        end
        if (clr_take_s && (clr_ch == in_ch)) begin
            prev_s = '0;
        end else begin
            prev_s = prev_s;
        end
    end

    // Form both shifted terms in W+1 bits so their sum cannot wrap before saturation.
    always_comb begin
        prev_ext_s = {prev_s[W-1], prev_s};
        x_ext_s    = {x[W-1], x};
        fb_term_s  = prev_ext_s >>> A_SHIFT;
        in_term_s  = x_ext_s >>> B_SHIFT;
        sum_s      = fb_term_s + in_term_s;
    end

    iir_sat #(
        .W (W)
    ) u_sat (
        .d    (sum_s),
        .q    (sat_y_s),
        .clip (sat_clip_s)
    );

    // Channel state: an accepted sample writes its result; otherwise a clear zeroes the channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (take_s && (in_ch == CW'(i))) begin
                    state_r[i] <= sat_y_s;
                end else if (clr_take_s && (clr_ch == CW'(i))) begin
                    state_r[i] <= '0;
                end else begin
                    state_r[i] <= state_r[i];
                end
            end
        end
    end

    // Output register: load on an accepted in-range sample, empty when drained, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            y_r         <= '0;
            out_ch_r    <= '0;
            sat_r       <= 1'b0;
        end else if (take_s) begin
            out_valid_r <= 1'b1;
            y_r         <= sat_y_s;
            out_ch_r    <= in_ch;
            sat_r       <= sat_clip_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            y_r         <= y_r;
            out_ch_r    <= out_ch_r;
            sat_r       <= sat_r;
        end else begin
            out_valid_r <= out_valid_r;
            y_r         <= y_r;
            out_ch_r    <= out_ch_r;
            sat_r       <= sat_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign out_ch    = out_ch_r;
    assign sat       = sat_r;

endmodule

// File: tb/tb_iir1_shift_filter.sv
// Directed scoreboard bench for iir1_shift_filter: instance A uses the default
// coefficients, instance B uses unity coefficients with three channels.
module tb_iir1_shift_filter;

    typedef struct {
        int y;
        int ch;
        int sat;
    } exp_t;

    logic clk;
    logic rst_n;

    logic              a_in_valid, a_in_ready, a_clr, a_out_valid, a_out_ready, a_sat;
    logic signed [7:0] a_x, a_y;
    logic [1:0]        a_in_ch, a_clr_ch, a_out_ch;

    logic              b_in_valid, b_in_ready, b_clr, b_out_valid, b_out_ready, b_sat;
    logic signed [7:0] b_x, b_y;
    logic [1:0]        b_in_ch, b_clr_ch, b_out_ch;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp;
    int   n_err;

    iir1_shift_filter #(.W(8), .NCH(4), .A_SHIFT(2), .B_SHIFT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .in_ch(a_in_ch), .clr(a_clr), .clr_ch(a_clr_ch),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .y(a_y),
        .out_ch(a_out_ch), .sat(a_sat)
    );

    iir1_shift_filter #(.W(8), .NCH(3), .A_SHIFT(0), .B_SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .in_ch(b_in_ch), .clr(b_clr), .clr_ch(b_clr_ch),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .y(b_y),
        .out_ch(b_out_ch), .sat(b_sat)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one sample on instance d (0=A, 1=B); queue its expected result when it is accepted.
    task automatic send(input int d, input int ch, input int xv, input int ey, input int es, input bit want);
        exp_t e;
        bit   got;
        if (d == 0) begin
            a_in_valid = 1'b1; a_in_ch = ch[1:0]; a_x = xv[7:0];
        end else begin
            b_in_valid = 1'b1; b_in_ch = ch[1:0]; b_x = xv[7:0];
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((d == 0 && a_in_ready) || (d == 1 && b_in_ready)) got = 1'b1;
        end
        if (!got) begin
            check("send_timeout", 0, 1);
        end else if (want) begin
            e.y = ey; e.ch = ch; e.sat = es;
            if (d == 0) qa.push_back(e);
            else qb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stop();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance A: compare each output as it is handed downstream.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_out", 1, 0);
            end else begin
                e = qa.pop_front();
                check("a_y", a_y, e.y);
                check("a_ch", a_out_ch, e.ch);
                check("a_sat", a_sat, e.sat);
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_out", 1, 0);
            end else begin
                e = qb.pop_front();
                check("b_y", b_y, e.y);
                check("b_ch", b_out_ch, e.ch);
                check("b_sat", b_sat, e.sat);
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_x = '0; a_in_ch = '0; a_clr = 1'b0; a_clr_ch = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_x = '0; b_in_ch = '0; b_clr = 1'b0; b_clr_ch = '0; b_out_ready = 1'b1;

        // Reset state, before any clock edge.
        #3;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_y", a_y, 0);
        check("rst_ch", a_out_ch, 0);
        check("rst_sat", a_sat, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Basic sequence on ch0 with floor rounding of a negative input.
        send(0, 0, 64, 32, 0, 1);
        send(0, 0, 64, 40, 0, 1);
        send(0, 0, -3, 8, 0, 1);
        stop(); idle(2);

        // A lone clear leaves the output register alone.
        a_clr = 1'b1; a_clr_ch = 2'd0;
        idle(1);
        a_clr = 1'b0;
        @(negedge clk);
        check("clr_keeps_y", a_y, 8);
        check("clr_keeps_valid", a_out_valid, 0);
        @(posedge clk); #1;

        // Interleaved channels; untouched channels still read as zero.
        send(0, 0, 64, 32, 0, 1);
        send(0, 2, -64, -32, 0, 1);
        send(0, 0, 64, 40, 0, 1);
        send(0, 1, 0, 0, 0, 1);
        send(0, 3, 0, 0, 0, 1);

        // Clear colliding with a sample on the same channel, then on a different channel.
        a_clr = 1'b1; a_clr_ch = 2'd0;
        send(0, 0, 64, 32, 0, 1);
        a_clr_ch = 2'd2;
        send(0, 0, 0, 8, 0, 1);
        a_clr = 1'b0;
        send(0, 2, 0, 0, 0, 1);
        send(0, 0, 0, 2, 0, 1);
        stop(); idle(2);

        // Unity coefficients: positive and negative saturation, dropped sample and clear.
        send(1, 1, 100, 100, 0, 1);
        send(1, 1, 100, 127, 1, 1);
        send(1, 1, -100, 27, 0, 1);
        send(1, 1, -100, -73, 0, 1);
        send(1, 3, 5, 0, 0, 0);
        send(1, 1, 0, -73, 0, 1);
        stop();
        b_clr = 1'b1; b_clr_ch = 2'd3;
        idle(1);
        b_clr = 1'b0;
        send(1, 1, 0, -73, 0, 1);
        send(1, 0, -128, -128, 0, 1);
        send(1, 0, -128, -128, 1, 1);
        send(1, 2, 5, 5, 0, 1);
        stop(); idle(3);

        // Backpressure: output holds, then drains on the same edge a new sample is taken.
        a_out_ready = 1'b0;
        send(0, 1, 64, 32, 0, 1);
        stop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", a_in_ready, 0);
            check("bp_y_stable", a_y, 32);
            check("bp_valid", a_out_valid, 1);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        send(0, 1, 0, 8, 0, 1);
        stop(); idle(2);

        // Asynchronous reset while an output is pending.
        a_out_ready = 1'b0;
        send(0, 2, 64, 32, 0, 1);
        stop();
        @(negedge clk);
        check("pre_rst_valid", a_out_valid, 1);
        check("pre_rst_ch", a_out_ch, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_y", a_y, 0);
        check("mid_rst_ch", a_out_ch, 0);
        check("mid_rst_in_ready", a_in_ready, 1);
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        send(0, 0, 64, 32, 0, 1);
        send(0, 1, 0, 0, 0, 1);
        stop();

        // Let the scoreboards empty, bounded.
        for (int i = 0; i < 20; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
        end
        check("drain", qa.size() + qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iir1_shift_filter.md
IIR1_SHIFT_FILTER -- requirements
Module: iir1_shift_filter

Interface
REQ-001 Parameter W, default 8: signed data width of x and y, two's complement, legal range 4..24.
REQ-002 Parameter NCH, default 4: number of independent time-multiplexed channels, legal range 1..16.
REQ-003 Parameter A_SHIFT, default 2: feedback coefficient 2^-A_SHIFT, legal range 0..W-1.
REQ-004 Parameter B_SHIFT, default 1: input coefficient 2^-B_SHIFT, legal range 0..W-1.
REQ-005 Port clk, input, 1: the block's one clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1: x, in_ch are valid this cycle.
REQ-008 Port in_ready, output, 1: block can accept a sample this cycle.
REQ-009 Port x, input, W: signed input sample.
REQ-010 Port in_ch, input, CW = max(1, clog2(NCH)): channel index of x.
REQ-011 Port clr, input, 1: pulse that zeroes the state of channel clr_ch.
REQ-012 Port clr_ch, input, CW: channel to clear.
REQ-013 Port out_valid, output, 1: y, out_ch and sat are valid.
REQ-014 Port out_ready, input, 1: downstream accepts the output this cycle.
REQ-015 Port y, output, W: signed filtered result.
REQ-016 Port out_ch, output, CW: channel index of y.
REQ-017 Port sat, output, 1: y was clipped.

Function
REQ-018 The block SHALL compute, per channel c, y_c(n) = (y_c(n-1) >>> A_SHIFT) + (x(n) >>> B_SHIFT), using arithmetic right shifts (floor toward minus infinity).
REQ-019 The sum SHALL be formed in W+1 bits and then saturated to [-2^(W-1), 2^(W-1)-1], with sat=1 when clipping occurs.
REQ-020 The state of each channel SHALL be the saturated y value it last produced.
REQ-021 A sample SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-022 in_ready SHALL equal (!out_valid || out_ready); this is a one-entry output register with backpressure.
REQ-023 Latency: y, out_ch and sat SHALL be registered, and out_valid SHALL rise on the edge that accepts the sample.
REQ-024 out_valid SHALL fall on the edge where out_valid=1, out_ready=1 and no new sample is accepted.
REQ-025 While out_valid=1 and out_ready=0, y, out_ch and sat SHALL hold stable.
REQ-026 The channel state SHALL update on the accepting edge, so a back-to-back sample on the same channel uses the just-produced y with no hazard.
REQ-027 Channels SHALL be independent: a sample on channel c SHALL NOT alter the state of any other channel.
REQ-028 On clr=1, the state of clr_ch SHALL become 0 at that edge; the y and out_valid registers SHALL NOT change.
REQ-029 If clr and an accepted sample target the same channel in one cycle, the sample SHALL use y(n-1)=0, and the stored state SHALL become the new result.
REQ-030 If clr and an accepted sample target different channels, both SHALL take effect independently.
REQ-031 If in_ch or clr_ch is >= NCH, the sample or clear SHALL be dropped. A dropped sample is still handshaken and produces no output, and no state changes.

Reset
REQ-032 While rst_n=0, independent of clk: all channel states, y, out_ch and sat SHALL be 0, out_valid SHALL be 0, and in_ready SHALL be 1.
REQ-033 Reset asserted mid-transaction SHALL discard the pending output without any partial update.
REQ-034 The first accepted sample after release SHALL see y(n-1)=0 on every channel.

Structure
REQ-035 Package iir_pkg SHALL hold shared constants: default W/NCH/A_SHIFT/B_SHIFT and the channel-width function.
REQ-036 Sub-module iir_sat SHALL be combinational, taking a (W+1)-bit input and producing a W-bit result plus a clip flag.
REQ-037 Channel state SHALL be an NCH x W register array; no RAM macro is used.

Verification
REQ-038 Defaults, ch0: x=64, then x=64, then x=-3 with out_ready=1 -> y=32, then 40, then 8 (10 + floor(-1.5) = -2), sat=0 throughout.
REQ-039 A_SHIFT=0, B_SHIFT=0, W=8: x=100, 100 on ch1 -> y=100, then 127 with sat=1; x=-100, -100 -> y=27, then -73.
REQ-040 Interleaving: ch0 x=64, ch2 x=-64, ch0 x=64 -> y=32 (ch0), -32 (ch2), 40 (ch0); ch1 and ch3 states remain 0.
REQ-041 Backpressure: hold out_ready=0 for 3 cycles after the first output -> in_ready=0 and y stable. Then out_ready=1 with in_valid=1 -> output drains and the new sample is accepted on the same edge.
REQ-042 Clear collision: ch0 state=40, then clr=1, clr_ch=0 with accepted x=64 on ch0 -> y=32.
REQ-043 Reset: assert rst_n=0 asynchronously while out_valid=1 -> out_valid, y and states go to 0 immediately; after release, x=64 on ch0 -> y=32.
